// File: rtl/memarb_pkg.sv
// memarb_pkg: shared state encoding, owner codes and alignment masks for memory_port_arbiter
package memarb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  localparam logic OWN_SCALAR = 1'b0;
  localparam logic OWN_VECTOR = 1'b1;
  localparam logic [2:0] S_ALIGN_MASK = 3'b011;
  localparam logic [2:0] V_ALIGN_MASK = 3'b111;
  function automatic logic misaligned(input logic [2:0] lsb, input logic [2:0] mask);
    return |(lsb & mask);
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, one-hot {vector, scalar}
module rr_arbiter2
  import memarb_pkg::*;
(
  input  logic       s_req,
  input  logic       v_req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb grant = (s_req && v_req) ? ((last == OWN_VECTOR) ? 2'b01 : 2'b10) : {v_req, s_req};
endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: round-robin sequencer sharing one memory port between scalar and vector units
module memory_port_arbiter
  import memarb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int VIN_W        = 64,
  parameter int VOUT_W       = 128,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_done,
  output logic              s_err,
  output logic [DATA_W-1:0] s_rdata,
  input  logic              v_req,
  input  logic              v_we,
  input  logic [ADDR_W-1:0] v_address,
  input  logic [VIN_W-1:0]  v_wdata,
  output logic              v_done,
  output logic              v_err,
  output logic [VOUT_W-1:0] v_rdata,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_input,
  output logic [VIN_W-1:0]  mem_vector_input,
  input  logic [DATA_W-1:0] mem_data_output,
  input  logic [VOUT_W-1:0] mem_vector_output,
  output logic              busy,
  output logic              owner
);
  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);
  state_t state, state_n;
  logic [1:0] grant, cnt;
  logic own, we_q, err_q, sel_we, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  rr_arbiter2 u_arb (.s_req(s_req), .v_req(v_req), .last(own), .grant(grant));
  always_comb begin
    sel_we = grant[1] ? v_we : s_we;
    sel_addr = grant[1] ? v_address : s_address;
    sel_err = grant[1] ? misaligned(v_address[2:0], V_ALIGN_MASK) : misaligned(s_address[2:0], S_ALIGN_MASK);
    state_n = state;
    case (state)
      IDLE:    state_n = !(|grant) ? IDLE : sel_err ? DONE : ACCESS;
      ACCESS:  state_n = we_q ? DONE : WAIT;
      WAIT:    state_n = (cnt == 2'd0) ? DONE : WAIT;
      default: state_n = IDLE;
    endcase
    busy = state != IDLE;
    owner = own;
    s_done = state == DONE && own == OWN_SCALAR;
    v_done = state == DONE && own == OWN_VECTOR;
    s_err = s_done && err_q;
    v_err = v_done && err_q;
  end
  // The memory-side registers double as the request latch: they load on the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      own <= OWN_VECTOR;
      we_q <= 1'b0;
      err_q <= 1'b0;
      cnt <= 2'd0;
      mem_write_enable <= 1'b0;
      mem_address <= '0;
      mem_data_input <= '0;
      mem_vector_input <= '0;
      s_rdata <= '0;
      v_rdata <= '0;
    end else begin
      state <= state_n;
      mem_write_enable <= 1'b0;
      if (state == IDLE && |grant) begin
        own <= grant[1];
        we_q <= sel_we;
        err_q <= sel_err;
        if (!sel_err) begin
          mem_address <= sel_addr;
          mem_write_enable <= sel_we;
          if (sel_we && grant[1]) mem_vector_input <= v_wdata;
          if (sel_we && !grant[1]) mem_data_input <= s_wdata;
        end
      end
      if (state == ACCESS) cnt <= LAT_INIT;
      if (state == WAIT) cnt <= cnt - 2'd1;
      if (state == WAIT && cnt == 2'd0 && own == OWN_VECTOR) v_rdata <= mem_vector_output;
      if (state == WAIT && cnt == 2'd0 && own == OWN_SCALAR) s_rdata <= mem_data_output;
    end
  end
endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Sequencer and arbiter sharing the single processor-side port of the I/O memory between the scalar load/store unit and the vector unit. Accepts one request per requester via a level req / pulse done handshake, grants round-robin, drives the memory's write enable, address and data lines for exactly one access, and returns read data after a fixed memory latency. Sits between the execute/memory pipeline stage and the I/O memory; the GPU-side port of the memory is untouched.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, scalar data width
- VIN_W, 64, vector write data width
- VOUT_W, 128, vector read data width
- READ_LATENCY, 1, cycles from address presentation to valid read data (legal 1..4)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- s_req  in  1  scalar request, held high until s_done
- s_we  in  1  scalar write (1) / read (0)
- s_address  in  ADDR_W  scalar byte address, must be 4-byte aligned
- s_wdata  in  DATA_W  scalar write data
- s_done  out  1  one-cycle completion pulse
- s_err  out  1  with s_done: misaligned, no memory access made
- s_rdata  out  DATA_W  scalar read data, valid with s_done on a read
- v_req, v_we, v_address, v_wdata(VIN_W), v_done, v_err  same roles for vector unit; v_address must be 8-byte aligned
- v_rdata  out  VOUT_W  vector read data, valid with v_done on a read
- mem_write_enable  out  1  memory write strobe
- mem_address  out  ADDR_W  memory address
- mem_data_input  out  DATA_W  scalar write data to memory
- mem_vector_input  out  VIN_W  vector write data to memory
- mem_data_output  in  DATA_W  scalar read data from memory
- mem_vector_output  in  VOUT_W  vector read data from memory
- busy  out  1  high in any state other than IDLE
- owner  out  1  current/last grant: 0 scalar, 1 vector

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: if any req, choose winner, latch we/address/wdata/owner; misaligned -> DONE with err; else -> ACCESS.
- Round-robin: both req in IDLE -> grant the requester that is not the last owner; single req -> granted. Reset last owner = vector, so scalar wins the first tie.
- ACCESS (1 cycle): mem_address = latched address; write: mem_write_enable=1, write data driven, -> DONE; read: -> WAIT with counter = READ_LATENCY-1 (READ_LATENCY=1 goes straight to capture).
- WAIT: decrement; at 0 capture mem_data_output or mem_vector_output per owner into rdata register, -> DONE.
- DONE (1 cycle): done (and err if set) of owner high, rdata stable; -> IDLE.
- Requester input changes after latch are ignored. A req still high in the IDLE after done counts as a new request.
- mem_write_enable high only in ACCESS of a write; never on err.
- Idle memory outputs hold their last values; write enable 0.
- rdata registers hold until the next read by the same requester.

## Timing
- Reset values: state IDLE, all done/err 0, mem_write_enable 0, mem_address 0, mem data outputs 0, rdata 0, busy 0, owner 1.
- rst mid-transaction: IDLE at next edge, pending done discarded, write enable dropped the same edge.
- Request sampled at edge n (IDLE): ACCESS in cycle n+1.
- Write: strobe in cycle n+1, done in cycle n+2. Throughput: one write per 3 cycles.
- Read: data captured at end of cycle n+1+READ_LATENCY, done/rdata in cycle n+2+READ_LATENCY.
- Error: done+err in cycle n+1.
- Losing requester waits; it is granted in the IDLE following the winner's DONE (worst-case wait: one full transaction + 1 cycle).

## Structure
- Package memarb_pkg: state enum (IDLE, ACCESS, WAIT, DONE), owner constants OWN_SCALAR=0 / OWN_VECTOR=1, alignment mask constants.
- Sub-module rr_arbiter2: two requests + last-owner register in, one-hot grant out. Everything else stays in the top.

## Test plan
- Scalar write s_address=0x100, s_wdata=0xA -> mem_write_enable one cycle with mem_address=0x100, mem_data_input=0xA; s_done 2 cycles after the request edge.
- Vector write v_address=0x404, v_wdata=0x1234567890ABCDEF -> v_err=1, v_done next cycle, no write strobe; repeat at 0x408 -> strobe, mem_vector_input=0x1234567890ABCDEF.
- Scalar read 0x30000 with READ_LATENCY=1 and 3, memory model returning 0xDEADBEEF -> s_rdata=0xDEADBEEF with s_done at cycle n+3 and n+5 respectively.
- s_req and v_req raised in the same cycle, held, for 4 transactions -> grants alternate scalar, vector, scalar, vector; first grant scalar after reset.
- rst asserted during WAIT of a vector read -> next cycle busy=0, v_done never pulses, mem_write_enable 0; a following scalar write completes normally.
- Misaligned scalar s_address=0x102 -> s_done+s_err one cycle after the request, memory outputs unchanged.
